// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM port, decode handshake and redirect bundle for the fetch stage
interface instr_fetch_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic rom_read;
  logic rom_ena;
  logic [DATA_W-1:0] rom_data;
  logic ir_valid;
  logic ir_ready;
  logic [DATA_W-1:0] ir_opcode;
  logic [DATA_W-1:0] ir_operand;
  logic ir_two_byte;
  logic [ADDR_W-1:0] ir_pc;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic halted;
  modport master (
    output rom_addr, rom_read, rom_ena, ir_valid, ir_opcode, ir_operand, ir_two_byte, ir_pc, halted,
    input rom_data, ir_ready, redirect_valid, redirect_addr
  );
  modport slave (
    input rom_addr, rom_read, rom_ena, ir_valid, ir_opcode, ir_operand, ir_two_byte, ir_pc, halted,
    output rom_data, ir_ready, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 1/2-byte instructions from ROM and hands them to decode via valid/ready
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {F_OP, F_ARG, OUT, HALT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic fetching, two_byte;
  assign fetching = (state == F_OP || state == F_ARG) && !rst;
  assign two_byte = bus.rom_data[7:4] inside {4'h1, 4'h2, 4'h3, 4'hA};
  assign bus.rom_addr = pc;
  assign bus.rom_read = fetching;
  assign bus.rom_ena = fetching;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= F_OP;
      bus.ir_valid <= 1'b0;
      bus.ir_opcode <= '0;
      bus.ir_operand <= '0;
      bus.ir_two_byte <= 1'b0;
      bus.ir_pc <= '0;
      bus.halted <= 1'b0;
    end else if (bus.redirect_valid && state != HALT) begin
      pc <= bus.redirect_addr;
      bus.ir_valid <= 1'b0;
      state <= F_OP;
    end else begin
      case (state)
        F_OP: begin
          bus.ir_opcode <= bus.rom_data;
          bus.ir_pc <= pc;
          bus.ir_operand <= '0;
          bus.ir_two_byte <= two_byte;
          pc <= pc + 1'b1;
          state <= two_byte ? F_ARG : OUT;
          bus.ir_valid <= !two_byte;
        end
        F_ARG: begin
          bus.ir_operand <= bus.rom_data;
          pc <= pc + 1'b1;
          state <= OUT;
          bus.ir_valid <= 1'b1;
        end
        OUT: if (bus.ir_ready) begin
          bus.ir_valid <= 1'b0;
          state <= (bus.ir_opcode[7:4] == 4'hF) ? HALT : F_OP;
          bus.halted <= bus.ir_opcode[7:4] == 4'hF;
        end
        default: ;
      endcase
    end
  end
endmodule
